// File: rtl/sys_cntr_pkg.sv
// Shared types and constants for the transmit-side system controller.
package sys_cntr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_SEND = 2'b01,
    ALU_LO  = 2'b10,
    ALU_HI  = 2'b11
  } tx_state_t;

  localparam int WIDTH_DEF = 8;

  // ALU results leave low byte first.
  localparam bit LOW_BYTE_FIRST = 1'b1;

endpackage

// File: rtl/tx_hold_slot.sv
// One-deep holding buffer with a pending flag.
// A strobe that finds the slot busy and not freeing is dropped and flagged.
module tx_hold_slot #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             free,
  output logic [width-1:0] slot_data,
  output logic             pend,
  output logic             overflow
);

  logic can_load;

  // A slot emptied by acceptance at this edge may refill at the same edge.
  assign can_load = !pend || free;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      slot_data <= '0;
      pend      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= load && !can_load;
      if (load && can_load) begin
        slot_data <= load_data;
        pend      <= 1'b1;
      end else if (free) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sys_cntr_tx.sv
// Transmit-side controller: buffers register-read and ALU responses and
// serialises them as bytes into the TX FIFO (read response has priority).
module sys_cntr_tx
  import sys_cntr_pkg::*;
#(
  parameter int width     = WIDTH_DEF,
  parameter int alu_width = 2 * width
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [width-1:0]     RdData,
  input  logic                 RdData_Valid,
  input  logic [alu_width-1:0] ALU_OUT,
  input  logic                 ALU_OUT_Valid,
  input  logic                 FIFO_Full,
  output logic [width-1:0]     FIFO_WrData,
  output logic                 FIFO_WrEN,
  output logic                 Busy,
  output logic                 Overflow,
  output tx_state_t            state_dbg
);

  tx_state_t            state, state_nxt;
  logic [width-1:0]     rd_buf;
  logic [alu_width-1:0] alu_buf;
  logic                 rd_pend, alu_pend;
  logic                 rd_ovf, alu_ovf;
  logic                 rd_free, alu_free;
  logic [width-1:0]     alu_first, alu_second;

  assign alu_first  = LOW_BYTE_FIRST ? alu_buf[width-1:0] : alu_buf[alu_width-1:width];
  assign alu_second = LOW_BYTE_FIRST ? alu_buf[alu_width-1:width] : alu_buf[width-1:0];

  // A slot frees only when its final byte is accepted by the FIFO.
  assign rd_free  = (state == RD_SEND) && FIFO_WrEN;
  assign alu_free = (state == ALU_HI)  && FIFO_WrEN;

  tx_hold_slot #(.width(width)) u_rd_slot (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (RdData_Valid),
    .load_data (RdData),
    .free      (rd_free),
    .slot_data (rd_buf),
    .pend      (rd_pend),
    .overflow  (rd_ovf)
  );

  tx_hold_slot #(.width(alu_width)) u_alu_slot (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (ALU_OUT_Valid),
    .load_data (ALU_OUT),
    .free      (alu_free),
    .slot_data (alu_buf),
    .pend      (alu_pend),
    .overflow  (alu_ovf)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Write strobe depends on state and FIFO_Full only; a stall holds state and data.
  always_comb begin
    state_nxt   = state;
    FIFO_WrEN   = 1'b0;
    FIFO_WrData = '0;
    case (state)
      IDLE: begin
        if (rd_pend)       state_nxt = RD_SEND;
        else if (alu_pend) state_nxt = ALU_LO;
      end
      RD_SEND: begin
        FIFO_WrEN   = !FIFO_Full;
        FIFO_WrData = rd_buf;
        if (!FIFO_Full) state_nxt = IDLE;
      end
      ALU_LO: begin
        FIFO_WrEN   = !FIFO_Full;
        FIFO_WrData = alu_first;
        if (!FIFO_Full) state_nxt = ALU_HI;
      end
      ALU_HI: begin
        FIFO_WrEN   = !FIFO_Full;
        FIFO_WrData = alu_second;
        if (!FIFO_Full) state_nxt = IDLE;
      end
    endcase
  end

  assign Busy      = rd_pend || alu_pend || (state != IDLE);
  assign Overflow  = rd_ovf || alu_ovf;
  assign state_dbg = state;

endmodule

// File: tb/tb_sys_cntr_tx.sv
// Bench for sys_cntr_tx: directed timing checks plus a byte scoreboard
// fed when strobes are driven and drained as the FIFO accepts writes.
module tb_sys_cntr_tx;
  import sys_cntr_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic        FIFO_Full;
  logic [7:0]  FIFO_WrData;
  logic        FIFO_WrEN;
  logic        Busy;
  logic        Overflow;
  tx_state_t   state_dbg;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_ovf    = 0;

  sys_cntr_tx dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .RdData        (RdData),
    .RdData_Valid  (RdData_Valid),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_Valid (ALU_OUT_Valid),
    .FIFO_Full     (FIFO_Full),
    .FIFO_WrData   (FIFO_WrData),
    .FIFO_WrEN     (FIFO_WrEN),
    .Busy          (Busy),
    .Overflow      (Overflow),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drivers: each returns 1 time unit after the sampling edge
  task automatic strobe_rd(input logic [7:0] d, input bit expect_sent);
    RdData = d;
    RdData_Valid = 1'b1;
    if (expect_sent) exp_q.push_back(d);
    tick();
    RdData_Valid = 1'b0;
  endtask

  task automatic strobe_alu(input logic [15:0] d);
    ALU_OUT = d;
    ALU_OUT_Valid = 1'b1;
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
    tick();
    ALU_OUT_Valid = 1'b0;
  endtask

  task automatic strobe_both(input logic [7:0] r, input logic [15:0] a);
    RdData = r;
    ALU_OUT = a;
    RdData_Valid = 1'b1;
    ALU_OUT_Valid = 1'b1;
    exp_q.push_back(r);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(a[15:8]);
    tick();
    RdData_Valid = 1'b0;
    ALU_OUT_Valid = 1'b0;
  endtask

  // scoreboard: a byte is accepted at the edge following a cycle with WrEN high
  always @(negedge CLK) begin
    logic [7:0] e;
    if (Reset && FIFO_WrEN) begin
      n_writes++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_data", 32'(FIFO_WrData), 32'(e));
      end
    end
    if (Reset && Overflow) n_ovf++;
  end

  initial begin
    int w0;
    int kind;
    logic [7:0]  rv;
    logic [15:0] av;
    bit drained;

    Reset = 1'b0;
    RdData = '0;
    RdData_Valid = 1'b0;
    ALU_OUT = '0;
    ALU_OUT_Valid = 1'b0;
    FIFO_Full = 1'b0;
    tick();
    tick();
    check("rst_wren", 32'(FIFO_WrEN), 32'd0);
    check("rst_data", 32'(FIFO_WrData), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    Reset = 1'b1;
    tick();

    // single read
    w0 = n_writes;
    strobe_rd(8'h5A, 1'b1);
    check("rd_busy_k", 32'(Busy), 32'd1);
    check("rd_wren_k", 32'(FIFO_WrEN), 32'd0);
    tick();
    check("rd_wren_k1", 32'(FIFO_WrEN), 32'd1);
    check("rd_data_k1", 32'(FIFO_WrData), 32'h5A);
    tick();
    check("rd_wren_k2", 32'(FIFO_WrEN), 32'd0);
    check("rd_busy_k2", 32'(Busy), 32'd0);
    check("rd_nwrites", 32'(n_writes - w0), 32'd1);

    // ALU result
    strobe_alu(16'hBEEF);
    check("alu_wren_k", 32'(FIFO_WrEN), 32'd0);
    tick();
    check("alu_lo_k1", 32'(FIFO_WrData), 32'hEF);
    check("alu_lo_en", 32'(FIFO_WrEN), 32'd1);
    tick();
    check("alu_hi_k2", 32'(FIFO_WrData), 32'hBE);
    check("alu_hi_en", 32'(FIFO_WrEN), 32'd1);
    tick();
    check("alu_busy_k3", 32'(Busy), 32'd0);

    // simultaneous strobes
    strobe_both(8'h11, 16'h2233);
    tick();
    check("sim_rd_k1", 32'(FIFO_WrData), 32'h11);
    tick();
    check("sim_gap_k2", 32'(FIFO_WrEN), 32'd0);
    tick();
    check("sim_lo_k3", 32'(FIFO_WrData), 32'h33);
    tick();
    check("sim_hi_k4", 32'(FIFO_WrData), 32'h22);
    tick();
    check("sim_busy_k5", 32'(Busy), 32'd0);

    // back-pressure in ALU_LO
    strobe_alu(16'hA5C3);
    FIFO_Full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_wren", 32'(FIFO_WrEN), 32'd0);
      check("bp_hold", 32'(FIFO_WrData), 32'hC3);
    end
    FIFO_Full = 1'b0;
    #0;
    check("bp_rel_lo", 32'(FIFO_WrData), 32'hC3);
    tick();
    check("bp_rel_hi", 32'(FIFO_WrData), 32'hA5);
    tick();
    check("bp_busy", 32'(Busy), 32'd0);

    // overflow on a busy, stalled rd slot
    w0 = n_ovf;
    FIFO_Full = 1'b1;
    strobe_rd(8'h01, 1'b1);
    strobe_rd(8'h02, 1'b0);
    check("ovf_pulse", 32'(Overflow), 32'd1);
    tick();
    check("ovf_clear", 32'(Overflow), 32'd0);
    FIFO_Full = 1'b0;
    tick();
    tick();
    tick();
    check("ovf_count", 32'(n_ovf - w0), 32'd1);
    check("ovf_busy", 32'(Busy), 32'd0);

    // strobe coinciding with acceptance is captured
    strobe_rd(8'h33, 1'b1);
    check("cap_wren_pre", 32'(FIFO_WrEN), 32'd0);
    tick();
    strobe_rd(8'h44, 1'b1);
    check("cap_no_ovf", 32'(Overflow), 32'd0);
    check("cap_busy", 32'(Busy), 32'd1);
    tick();
    check("cap_data", 32'(FIFO_WrData), 32'h44);
    tick();
    check("cap_busy_end", 32'(Busy), 32'd0);

    // reset between ALU low and high bytes
    ALU_OUT = 16'h7788;
    ALU_OUT_Valid = 1'b1;
    exp_q.push_back(8'h88);
    tick();
    ALU_OUT_Valid = 1'b0;
    tick();
    check("mr_lo", 32'(FIFO_WrData), 32'h88);
    tick();
    Reset = 1'b0;
    #1;
    check("mr_wren", 32'(FIFO_WrEN), 32'd0);
    check("mr_data", 32'(FIFO_WrData), 32'd0);
    check("mr_busy", 32'(Busy), 32'd0);
    check("mr_ovf", 32'(Overflow), 32'd0);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_idle", 32'(FIFO_WrEN), 32'd0);
    end

    // random traffic with random back-pressure
    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 2);
      rv = 8'($urandom_range(0, 255));
      av = 16'($urandom_range(0, 65535));
      if (kind == 0)      strobe_rd(rv, 1'b1);
      else if (kind == 1) strobe_alu(av);
      else                strobe_both(rv, av);
      drained = 1'b0;
      for (int c = 0; c < 200 && !drained; c++) begin
        FIFO_Full = ($urandom_range(0, 2) == 0);
        tick();
        if (!Busy) drained = 1'b1;
      end
      FIFO_Full = 1'b0;
      check("rand_drain", 32'(drained), 32'd1);
    end

    tick();
    check("q_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_total", 32'(n_ovf), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_cntr_tx.md
# sys_cntr_tx

Transmit-side system controller. It collects responses produced after the receive-side controller issues commands: register-file read data, and 16-bit ALU results. It serialises them into bytes and pushes the bytes into the UART transmit FIFO through a write/full handshake. It sits between the register file/ALU outputs and the TX FIFO write port, and it buffers one response of each kind so a response is never lost while the FIFO is full.

## Interface
- `width`, 8: byte width of the register-file data and the FIFO data.
- `alu_width`, 2*`width`: ALU result width. It is always 2*`width`.
- `CLK`  in  1  single system clock. Everything is sampled on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `RdData`  in  `width`  register-file read data.
- `RdData_Valid`  in  1  one-cycle strobe; `RdData` is valid in this cycle.
- `ALU_OUT`  in  `alu_width`  ALU result.
- `ALU_OUT_Valid`  in  1  one-cycle strobe; `ALU_OUT` is valid in this cycle.
- `FIFO_Full`  in  1  the TX FIFO cannot accept a write in this cycle.
- `FIFO_WrData`  out  `width`  byte being written to the FIFO.
- `FIFO_WrEN`  out  1  write strobe. The FIFO accepts the byte at the rising edge that ends this cycle.
- `Busy`  out  1  a response is pending or being sent.
- `Overflow`  out  1  one-cycle pulse: a valid strobe was dropped.

## Operation
- Two holding slots:
  - rd slot: a `width` buffer plus an rd_pend flag.
  - alu slot: an `alu_width` buffer plus an alu_pend flag.
- Capture rules:
  - `RdData_Valid` loads the rd slot and sets rd_pend.
  - This is allowed if rd_pend=0, or if the rd byte is accepted by the FIFO in the same cycle.
  - The same rule applies to the alu slot. The alu slot is freed by acceptance of its high byte.
  - A strobe arriving while its slot is occupied and not freeing in that cycle is dropped. The buffer and flag are unchanged, and `Overflow`=1 in the next cycle.
- The two strobes may arrive in the same cycle; both are captured independently.
- FSM states: IDLE, RD_SEND, ALU_LO, ALU_HI.
  - IDLE: if rd_pend, go to RD_SEND. Otherwise, if alu_pend, go to ALU_LO. Otherwise stay. The read response has priority.
  - RD_SEND: drive the rd buffer. On acceptance, clear rd_pend and go to IDLE.
  - ALU_LO: drive alu buffer [`width`-1:0]. On acceptance, go to ALU_HI.
  - ALU_HI: drive alu buffer [`alu_width`-1:`width`]. On acceptance, clear alu_pend and go to IDLE.
- Write handshake:
  - In a send state, `FIFO_WrEN` = !`FIFO_Full`. It is decoded from the state and `FIFO_Full` only.
  - Acceptance means `FIFO_WrEN`=1 at a clock edge.
  - While `FIFO_Full`=1 the state holds and `FIFO_WrData` stays stable. No timeout.
- Output values:
  - `FIFO_WrData` is 0 in IDLE.
  - `Busy` = rd_pend | alu_pend | (state != IDLE).
- Byte order is fixed: the ALU low byte is always sent first.
- No arithmetic is performed. Data passes through bit-exact.

## Timing
- Reset values:
  - state IDLE; buffers 0; flags 0.
  - `FIFO_WrEN`=0, `FIFO_WrData`=0, `Busy`=0, `Overflow`=0.
- Reset asserted mid-transfer aborts immediately. Partially sent ALU results are discarded and nothing is resent.
- Read latency: strobe sampled at edge k, then rd_pend=1 after k. State is RD_SEND after k+1, and `FIFO_WrEN`=1 in that cycle. The byte is accepted at edge k+2 if the FIFO is not full.
- ALU latency: strobe at edge k, then low byte accepted at k+2 and high byte at k+3, with no full cycles.
- If both kinds of strobe arrive at edge k: the rd byte is accepted at k+2, IDLE at k+3, then the ALU bytes at k+4 and k+5.
- Each stall cycle with `FIFO_Full`=1 adds exactly one cycle.
- `Busy` rises the cycle after the capturing edge. It falls the cycle after the last acceptance, unless more data is pending.
- `Overflow` is registered and high for exactly one cycle per dropped strobe.

## Structure
- Shared package `sys_cntr_pkg`:
  - state encoding: IDLE=2'b00, RD_SEND=2'b01, ALU_LO=2'b10, ALU_HI=2'b11.
  - `width` default.
  - byte-order constant (low byte first).
- One natural sub-module: `tx_hold_slot`, instantiated twice.
  - Parameterised data width; buffer plus pend flag.
  - Load/free/drop logic and the overflow pulse.
- The top level contains the FSM and output mux.

## Test plan
- Single read: `RdData`=8'h5A with a strobe at edge 0 and `FIFO_Full`=0. Expect exactly one write of 8'h5A, accepted at edge 2, and `Busy` 1→0.
- ALU result: `ALU_OUT`=16'hBEEF with a strobe. Expect writes 8'hEF at edge 2 and 8'hBE at edge 3.
- Simultaneous: read 8'h11 and ALU 16'h2233 strobed in the same cycle. Expect the write order 11, 33, 22.
- Back-pressure: `FIFO_Full`=1 for 5 cycles during ALU_LO with ALU 16'hA5C3. Expect `FIFO_WrEN` low throughout and `FIFO_WrData` held at 8'hC3; then C3 and A5 are written in the two cycles after release.
- Overflow:
  - With `FIFO_Full`=1 and a read 8'h01 pending, a second read 8'h02 is strobed. Expect `Overflow` pulsed once and only 8'h01 written after release.
  - A strobe in the same cycle as acceptance is captured, not dropped.
- Reset mid-send: assert `Reset` between the ALU low and high bytes. Expect all outputs 0 and no high byte after release.
